stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-input, W-bit stream multiplexer; successor to the 2-input combinational mux.
//  Selection is either manual (sel) or round-robin over valid inputs, with a valid/ready handshake on every channel.
//  Output is registered and a multi-beat packet (in_last) locks the grant until it completes.
//  Merges several producer streams into one consumer in datapath top levels.
// PARAMETERS
//  N      2   number of input channels (>=2)
//  W      1   data width per channel in bits (>=1)
//  SEL_W  localparam = $clog2(N); width of sel and out_chan
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  mode       in   1      0 = manual select via sel, 1 = round-robin
//  sel        in   SEL_W  channel index used when mode=0; values >= N select nothing
//  in_valid   in   N      per-channel beat valid
//  in_ready   out  N      per-channel accept, one-hot or zero
//  in_data    in   N*W    channel k occupies bits [k*W +: W]
//  in_last    in   N      per-channel end-of-packet flag
//  out_valid  out  1      output register holds a beat
//  out_ready  in   1      consumer accepts the beat
//  out_data   out  W      registered data
//  out_last   out  1      registered last flag
//  out_chan   out  SEL_W  index of the source channel of the current beat
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_chan=0, state=IDLE, rr_ptr=N-1.
//    in_ready=0 while rst_n=0.
//  slot_free = !out_valid | out_ready. in_ready[g] = slot_free & grant_valid & (g==grant).
//  Input accept = in_valid[g] & in_ready[g]. The output register loads in_data[g], in_last[g] and g on the next edge.
//  Latency 1 cycle. Full throughput: a beat drains and a new beat loads in the same cycle.
//  Output hold: while out_valid & !out_ready, out_data/out_last/out_chan stay stable and all in_ready=0.
//  No accept with slot_free: out_valid clears on the edge where out_ready=1.
//  Grant in IDLE:
//    mode=0: grant=sel if sel<N and in_valid[sel], else none.
//    mode=1: first valid channel scanning rr_ptr+1, rr_ptr+2, ... with wrap N-1 -> 0; none if no valid.
//  FSM states IDLE and LOCKED:
//    IDLE   -> LOCKED on an accept with in_last=0; lock_ch <= g.
//    IDLE   -> IDLE on an accept with in_last=1; rr_ptr <= g.
//    LOCKED: grant=lock_ch only, when in_valid[lock_ch]. mode and sel are ignored.
//    LOCKED -> IDLE on an accept from lock_ch with in_last=1; rr_ptr <= lock_ch.
//  rr_ptr only updates at packet end, so packets rotate, not beats. Single-beat packets rotate every beat.
//  Rules:
//    mode/sel changes take effect only in IDLE, on the next grant evaluation (combinational).
//    Producers must hold in_valid/in_data/in_last stable until accepted; the block does not check this.
//    Dropped in_valid on lock_ch while LOCKED: the grant stays, no other channel is served.
//    rst_n asserted mid-packet: lock and buffered beat are discarded immediately; state returns to IDLE.
//    N not a power of 2: sel >= N grants nothing; the rr scan wraps at N-1, never at 2^SEL_W.
// STRUCTURE
//  Package stream_mux_pkg: state encoding (ST_IDLE=1'b0, ST_LOCKED=1'b1), MODE_MANUAL=0, MODE_RR=1.
//  Sub-module rr_arbiter #(N):
//    inputs req[N], ptr[SEL_W]; outputs gnt_idx[SEL_W], gnt_valid.
//    Purely combinational rotate-priority; reused for future arbiters.
//  Top holds the FSM, rr_ptr, lock_ch, the output register and the in_ready decode.
// TESTING
//  Manual, N=2 W=1: mode=0, sel=1, in_valid=2'b11, data ch0=0 ch1=1, last=1, out_ready=1
//    -> out_data=1, out_chan=1 one cycle later; in_ready=2'b10.
//  Round-robin, N=4 W=8: mode=1, all valid, single-beat packets 8'hA0+k
//    -> out_chan sequence 0,1,2,3,0; one beat per cycle.
//  Packet lock: ch2 sends 3 beats (last on beat 3) while ch0 and ch3 stay valid
//    -> out_chan=2 for 3 consecutive beats, then 3, then 0.
//  Backpressure: out_ready=0 for 4 cycles with out_valid=1
//    -> out_data stable, in_ready=0; on release the beat is consumed once, no loss or duplication.
//  Reset mid-packet: rst_n=0 after ch1 beat 1 of 3 (last=0)
//    -> out_valid=0, in_ready=0 at once; after release, round-robin restarts at ch0.
//  Invalid sel, N=3: mode=0, sel=3, all valid -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: FSM state
// encoding and the meaning of the mode input.
package stream_mux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter. The request just after ptr has
// the highest priority and the scan wraps from N-1 back to 0, so ptr itself
// is the lowest-priority requester. Kept generic so other arbiters can reuse it.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan ptr+1, ptr+2, ... modulo N and take the first active request
  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input stream multiplexer with manual or round-robin selection, a
// registered output stage and packet locking: once a multi-beat packet has
// started, only its channel is served until its last beat is accepted.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_chan
);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_ch;

  logic [SEL_W-1:0] arb_idx;
  logic             arb_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             lock_valid;
  logic             sel_valid;
  logic             slot_free;
  logic             accept;
  logic [W-1:0]     grant_data;
  logic             grant_last;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Pick the granted channel: the locked channel mid-packet, otherwise sel or the arbiter
  always_comb begin
    lock_valid  = 1'b0;
    sel_valid   = 1'b0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (SEL_W'(k) == lock_ch) lock_valid = in_valid[k];
      if (SEL_W'(k) == sel)     sel_valid  = in_valid[k];
    end
    if (state == ST_LOCKED) begin
      grant       = lock_ch;
      grant_valid = lock_valid;
    end else if (mode == MODE_MANUAL) begin
      grant       = sel;
      grant_valid = sel_valid;
    end else begin
      grant       = arb_idx;
      grant_valid = arb_valid;
    end
  end

  // Decode the one-hot ready and mux the granted channel's payload
  always_comb begin
    slot_free  = !out_valid || out_ready;
    in_ready   = '0;
    grant_data = '0;
    grant_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (SEL_W'(k) == grant) begin
        in_ready[k] = rst_n && slot_free && grant_valid;
        grant_data  = in_data[k*W +: W];
        grant_last  = in_last[k];
      end
    end
    accept = |(in_valid & in_ready);
  end

  // Output register, packet-lock FSM and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= SEL_W'(N - 1);
      lock_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_last  <= grant_last;
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (grant_last) begin
              rr_ptr <= grant;
            end else begin
              lock_ch <= grant;
              state   <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (accept && grant_last) begin
            rr_ptr <= lock_ch;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
